netfpga_sume_10g_if_rx_fifo: RTL and testbench
==============================================

Name: netfpga_sume_10g_if_rx_fifo

Overview:
- Store-and-forward RX packet buffer between the 10GbE MAC receive AXI-Stream and the user datapath, in the clk156 domain.
- The MAC RX stream has no backpressure. This block absorbs frames, drops them cleanly (whole-frame) on overflow or FCS/error, and presents a fully backpressurable AXI-Stream master.
- Provides saturating per-cause frame counters.

Parameters:
- DATA_WIDTH, 64, stream data width in bits; multiple of 8.
- DEPTH, 512, buffer depth in DATA_WIDTH words; power of 2, >= 16.
- DROP_BAD_FRAMES, 1, 1 = discard frames with tuser=0 at tlast; 0 = forward them with m_axis_tuser=0.
- CNT_WIDTH, 32, width of statistics counters.

Ports:
- clk156  in  1  core clock, 156.25 MHz.
- aresetn  in  1  asynchronous active-low reset.
- s_axis_tdata  in  DATA_WIDTH  MAC RX data.
- s_axis_tkeep  in  DATA_WIDTH/8  byte enables.
- s_axis_tvalid  in  1  MAC RX valid; no tready exists.
- s_axis_tlast  in  1  last word of frame.
- s_axis_tuser  in  1  frame good; sampled only with tlast.
- m_axis_tdata  out  DATA_WIDTH  buffered data.
- m_axis_tkeep  out  DATA_WIDTH/8  buffered byte enables.
- m_axis_tvalid  out  1  output valid.
- m_axis_tlast  out  1  output last.
- m_axis_tuser  out  1  good flag, on the tlast word only; 1 on all other words.
- m_axis_tready  in  1  downstream ready.
- cnt_rx_good  out  CNT_WIDTH  frames committed.
- cnt_drop_ovf  out  CNT_WIDTH  frames dropped for buffer full.
- cnt_drop_err  out  CNT_WIDTH  frames dropped for tuser=0.

Behaviour:
- Single clock clk156. aresetn is asynchronous assert, synchronous deassert (external synchroniser). All state clears on assertion.
- Reset values: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, m_axis_tdata=0, m_axis_tkeep=0, all counters=0, buffer empty.
- Storage: dual-pointer RAM, pointers log2(DEPTH)+1 bits wide (MSB = wrap bit).
  - Pointers: wr_ptr (speculative), wr_commit, rd_ptr.
  - full = (wr_ptr - rd_ptr) == DEPTH.
  - Per word, the RAM stores tdata, tkeep, tlast and the good bit.
- Write FSM states:
  - SYNC, entered on reset:
    - s_axis_tvalid=1 in the first cycle → DROP (uncounted; joined mid-frame).
    - Otherwise → IDLE.
  - IDLE/RECV:
    - On each s_axis_tvalid word, if not full: write, increment wr_ptr.
    - If full: set wr_ptr=wr_commit, increment cnt_drop_ovf, → DROP, unless that word is tlast, in which case stay IDLE.
    - On an accepted tlast with tuser=1, or tuser=0 with DROP_BAD_FRAMES=0: wr_commit=wr_ptr+1, increment cnt_rx_good.
    - On tlast with tuser=0 and DROP_BAD_FRAMES=1: wr_ptr=wr_commit, increment cnt_drop_err.
  - DROP: discard words until tlast inclusive → IDLE. No further counting for that frame.
- A frame hitting full on its tlast word counts as overflow, not error.
- A frame longer than DEPTH is always dropped as overflow.
- Each frame increments exactly one counter. Counters saturate at 2^CNT_WIDTH-1.
- Read side:
  - Data is readable only in [rd_ptr, wr_commit); partial frames are never visible.
  - m_axis uses FWFT output registers with standard AXIS handshake: tdata/tkeep/tlast/tuser are held stable while tvalid=1 and tready=0.
  - Zero-bubble streaming at 1 word/cycle while tready=1 and data is committed.
- Latency: m_axis_tvalid rises exactly 2 cycles after the clock edge where a committing tlast is written, when the buffer was previously empty.
- Simultaneous events:
  - A read freeing a slot in the same cycle as a write is not seen by full until the next cycle (conservative).
  - Commit and read in the same cycle are both honoured.
- Reset mid-operation: buffered frames are lost. Output goes idle within the reset assertion. After release, the block enters SYNC.

Test Plan:
- Three frames of 8, 1 and 190 words, tuser=1, m_axis_tready=1 → identical data/tkeep/tlast out; first output 2 cycles after first tlast; cnt_rx_good=3, drops=0.
- DEPTH=16, m_axis_tready=0, frames of 10 and 10 words → frame 1 buffered; frame 2 dropped; cnt_drop_ovf=1. Raising tready then outputs only frame 1.
- DEPTH=16, single 20-word frame, tready=1 throughout → dropped, nothing output, cnt_drop_ovf=1. A following 4-word frame passes.
- Frame with tuser=0 at tlast: DROP_BAD_FRAMES=1 → no output, cnt_drop_err=1. DROP_BAD_FRAMES=0 → forwarded with m_axis_tuser=0 on tlast, cnt_rx_good=1.
- Random m_axis_tready (50%) over 1000 random frames → output stream matches all committed frames in order, no word lost or duplicated, outputs stable while stalled.
- Assert aresetn mid-frame, release with s_axis_tvalid=1 → tail discarded (no counter change); next full frame committed; CNT_WIDTH=4 with 20 good frames → cnt_rx_good=15.

Source files
------------

// File: rtl/netfpga_sume_10g_if_rx_fifo.sv
// netfpga_sume_10g_if_rx_fifo: store-and-forward 10GbE RX frame buffer with whole-frame drop and stats
module netfpga_sume_10g_if_rx_fifo #(
  parameter int DATA_WIDTH      = 64,
  parameter int DEPTH           = 512,
  parameter bit DROP_BAD_FRAMES = 1'b1,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                    clk156,
  input  logic                    aresetn,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tuser,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tuser,
  input  logic                    m_axis_tready,
  output logic [CNT_WIDTH-1:0]    cnt_rx_good,
  output logic [CNT_WIDTH-1:0]    cnt_drop_ovf,
  output logic [CNT_WIDTH-1:0]    cnt_drop_err
);
  localparam int KW = DATA_WIDTH / 8;
  localparam int AW = $clog2(DEPTH);
  localparam int EW = DATA_WIDTH + KW + 2;
  localparam logic [AW:0] ONE = (AW+1)'(1);
  localparam logic [1:0] ST_SYNC = 2'd0, ST_IDLE = 2'd1, ST_DROP = 2'd2;
  logic [EW-1:0] mem_q [DEPTH];
  logic [1:0] state_q, state_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d, wr_commit_q, wr_commit_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] cnt_good_q, cnt_good_d, cnt_ovf_q, cnt_ovf_d, cnt_err_q, cnt_err_d;
  logic a_valid_q, a_valid_d, m_valid_q, m_valid_d;
  logic [EW-1:0] a_word_q, a_word_d, m_word_q, m_word_d;
  logic full, wr_en, inc_good, inc_ovf, inc_err, move_a, rd_en;
  assign full = (wr_ptr_q - rd_ptr_q) == (AW+1)'(DEPTH);
  // Write side: speculative write pointer, committed only by an accepted good tlast
  always_comb begin
    state_d = state_q;
    wr_ptr_d = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    wr_en = 1'b0;
    inc_good = 1'b0;
    inc_ovf = 1'b0;
    inc_err = 1'b0;
    if (s_axis_tvalid) begin
      if (state_q != ST_IDLE) state_d = s_axis_tlast ? ST_IDLE : ST_DROP;
      else if (full) begin
        wr_ptr_d = wr_commit_q;
        inc_ovf = 1'b1;
        state_d = s_axis_tlast ? ST_IDLE : ST_DROP;
      end else begin
        wr_en = 1'b1;
        wr_ptr_d = wr_ptr_q + ONE;
        if (s_axis_tlast && (s_axis_tuser || !DROP_BAD_FRAMES)) begin
          wr_commit_d = wr_ptr_q + ONE;
          inc_good = 1'b1;
        end else if (s_axis_tlast) begin
          wr_ptr_d = wr_commit_q;
          inc_err = 1'b1;
        end
      end
    end else if (state_q == ST_SYNC) state_d = ST_IDLE;
    cnt_good_d = cnt_good_q + CNT_WIDTH'(inc_good && ~&cnt_good_q);
    cnt_ovf_d = cnt_ovf_q + CNT_WIDTH'(inc_ovf && ~&cnt_ovf_q);
    cnt_err_d = cnt_err_q + CNT_WIDTH'(inc_err && ~&cnt_err_q);
  end
  // Read side: RAM read register feeding the FWFT output register, one word per cycle
  always_comb begin
    move_a = a_valid_q && (!m_valid_q || m_axis_tready);
    rd_en = (!a_valid_q || move_a) && (rd_ptr_q != wr_commit_q);
    rd_ptr_d = rd_en ? rd_ptr_q + ONE : rd_ptr_q;
    a_valid_d = rd_en || (a_valid_q && !move_a);
    a_word_d = rd_en ? mem_q[rd_ptr_q[AW-1:0]] : a_word_q;
    m_valid_d = move_a || (m_valid_q && !m_axis_tready);
    m_word_d = move_a ? a_word_q : m_word_q;
  end
  // Frame storage: data, keep, last and good bit per word; no reset needed
  always_ff @(posedge clk156) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= {s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tlast ? s_axis_tuser : 1'b1};
  end
  // State registers, cleared asynchronously
  always_ff @(posedge clk156 or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_SYNC;
      wr_ptr_q <= '0;
      wr_commit_q <= '0;
      rd_ptr_q <= '0;
      cnt_good_q <= '0;
      cnt_ovf_q <= '0;
      cnt_err_q <= '0;
      a_valid_q <= 1'b0;
      a_word_q <= '0;
      m_valid_q <= 1'b0;
      m_word_q <= '0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      wr_commit_q <= wr_commit_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_good_q <= cnt_good_d;
      cnt_ovf_q <= cnt_ovf_d;
      cnt_err_q <= cnt_err_d;
      a_valid_q <= a_valid_d;
      a_word_q <= a_word_d;
      m_valid_q <= m_valid_d;
      m_word_q <= m_word_d;
    end
  end
  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} = m_word_q;
  assign m_axis_tvalid = m_valid_q;
  assign cnt_rx_good = cnt_good_q;
  assign cnt_drop_ovf = cnt_ovf_q;
  assign cnt_drop_err = cnt_err_q;
endmodule

// File: tb/tb_netfpga_sume_10g_if_rx_fifo.sv
// tb_netfpga_sume_10g_if_rx_fifo: directed bench, small-buffer/drop-bad instance A beside large/forward-bad instance B
module tb_netfpga_sume_10g_if_rx_fifo;
  logic clk156 = 1'b0;
  logic aresetn = 1'b0;
  logic [63:0] s_tdata = '0;
  logic [7:0] s_tkeep = '0;
  logic s_tvalid = 1'b0, s_tlast = 1'b0, s_tuser = 1'b0, tready = 1'b1;
  logic [63:0] a_tdata, b_tdata;
  logic [7:0] a_tkeep, b_tkeep;
  logic a_tvalid, a_tlast, a_tuser, b_tvalid, b_tlast, b_tuser;
  logic [3:0] a_good, a_ovf, a_err;
  logic [31:0] b_good, b_ovf, b_err;
  int checks = 0, errors = 0, ng = 0, nb = 0, len = 0, nv = 0;
  bit rnd = 1'b0;
  logic u;
  logic [73:0] w;
  logic [73:0] exp_a[$], exp_b[$];
  logic sa_q = 1'b0, sb_q = 1'b0;
  logic [73:0] wa_q = '0, wb_q = '0;
  always #5 clk156 = ~clk156;
  netfpga_sume_10g_if_rx_fifo #(.DATA_WIDTH(64), .DEPTH(16), .DROP_BAD_FRAMES(1'b1), .CNT_WIDTH(4)) u_a (
    .clk156(clk156), .aresetn(aresetn),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(a_tdata), .m_axis_tkeep(a_tkeep), .m_axis_tvalid(a_tvalid), .m_axis_tlast(a_tlast), .m_axis_tuser(a_tuser),
    .m_axis_tready(tready), .cnt_rx_good(a_good), .cnt_drop_ovf(a_ovf), .cnt_drop_err(a_err));
  netfpga_sume_10g_if_rx_fifo #(.DATA_WIDTH(64), .DEPTH(512), .DROP_BAD_FRAMES(1'b0), .CNT_WIDTH(32)) u_b (
    .clk156(clk156), .aresetn(aresetn),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(b_tdata), .m_axis_tkeep(b_tkeep), .m_axis_tvalid(b_tvalid), .m_axis_tlast(b_tlast), .m_axis_tuser(b_tuser),
    .m_axis_tready(tready), .cnt_rx_good(b_good), .cnt_drop_ovf(b_ovf), .cnt_drop_err(b_err));
  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [73:0] mk(input int id, input int i, input int n, input logic g);
    logic last;
    logic [7:0] k;
    logic [31:0] lo;
    last = (i == n - 1);
    k = last ? (8'hFF >> (id % 8)) : 8'hFF;
    lo = 32'(id * 7 + i) ^ 32'hC0DE_0000;
    return {id[15:0], 16'(i), lo, k, last, last ? g : 1'b1};
  endfunction
  task automatic step();
    @(posedge clk156);
    #1;
    if (rnd) tready = 1'($urandom_range(0, 1));
  endtask
  task automatic send(input int id, input int n, input logic g, input logic pa, input logic pb);
    logic [73:0] x;
    for (int i = 0; i < n; i++) begin
      x = mk(id, i, n, g);
      {s_tdata, s_tkeep, s_tlast} = x[73:1];
      s_tuser = g;
      s_tvalid = 1'b1;
      if (pa) exp_a.push_back(x);
      if (pb) exp_b.push_back(x);
      step();
    end
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
  endtask
  task automatic drain(input string tag);
    int n = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 400) begin
      step();
      n++;
    end
    chk(tag, 80'(exp_a.size() + exp_b.size()), 80'(0));
  endtask
  always @(negedge clk156) begin
    if (!aresetn) sa_q = 1'b0;
    else begin
      if (sa_q) chk("a_hold", {1'b1, a_tvalid, a_tdata, a_tkeep, a_tlast, a_tuser}, {2'b11, wa_q});
      if (a_tvalid && tready) begin
        chk("a_unexpected_word", 80'(exp_a.size() != 0), 80'(1));
        if (exp_a.size() != 0) chk("a_word", {6'd0, a_tdata, a_tkeep, a_tlast, a_tuser}, {6'd0, exp_a.pop_front()});
      end
      sa_q = a_tvalid && !tready;
      wa_q = {a_tdata, a_tkeep, a_tlast, a_tuser};
    end
  end
  always @(negedge clk156) begin
    if (!aresetn) sb_q = 1'b0;
    else begin
      if (sb_q) chk("b_hold", {1'b1, b_tvalid, b_tdata, b_tkeep, b_tlast, b_tuser}, {2'b11, wb_q});
      if (b_tvalid && tready) begin
        chk("b_unexpected_word", 80'(exp_b.size() != 0), 80'(1));
        if (exp_b.size() != 0) chk("b_word", {6'd0, b_tdata, b_tkeep, b_tlast, b_tuser}, {6'd0, exp_b.pop_front()});
      end
      sb_q = b_tvalid && !tready;
      wb_q = {b_tdata, b_tkeep, b_tlast, b_tuser};
    end
  end
  initial begin
    repeat (3) step();
    chk("rst_tvalid", 80'({a_tvalid, b_tvalid}), 80'(0));
    chk("rst_tdata", 80'(a_tdata | b_tdata), 80'(0));
    chk("rst_tkeep", 80'({a_tkeep, b_tkeep}), 80'(0));
    chk("rst_tlast_tuser", 80'({a_tlast, a_tuser, b_tlast, b_tuser}), 80'(0));
    chk("rst_cnt", 80'({a_good, a_ovf, a_err} | b_good | b_ovf | b_err), 80'(0));
    aresetn = 1'b1;
    repeat (3) step();
    send(1, 8, 1'b1, 1'b1, 1'b1);
    chk("lat_cycle0", 80'({a_tvalid, b_tvalid}), 80'(0));
    step();
    chk("lat_cycle1", 80'({a_tvalid, b_tvalid}), 80'(0));
    step();
    chk("lat_cycle2", 80'({a_tvalid, b_tvalid}), 80'(2'b11));
    repeat (12) step();
    send(2, 1, 1'b1, 1'b1, 1'b1);
    repeat (12) step();
    send(3, 190, 1'b1, 1'b0, 1'b1);
    step();
    nv = 0;
    repeat (190) begin
      step();
      nv += int'(b_tvalid);
    end
    chk("b_zero_bubble_beats", 80'(nv), 80'(190));
    step();
    chk("b_idle_after_stream", 80'(b_tvalid), 80'(0));
    drain("t1_drain");
    chk("t1_a_cnt", 80'({a_good, a_ovf, a_err}), 80'({4'd2, 4'd1, 4'd0}));
    chk("t1_b_cnt", {b_good, b_ovf, b_err[15:0]}, {32'd3, 32'd0, 16'd0});
    tready = 1'b0;
    send(4, 10, 1'b1, 1'b1, 1'b1);
    repeat (2) step();
    send(5, 10, 1'b1, 1'b0, 1'b1);
    repeat (5) step();
    chk("t2_stalled_valid", 80'({a_tvalid, b_tvalid}), 80'(2'b11));
    chk("t2_a_ovf", 80'({a_good, a_ovf}), 80'({4'd3, 4'd2}));
    tready = 1'b1;
    drain("t2_drain");
    send(6, 4, 1'b1, 1'b1, 1'b1);
    drain("t3_drain");
    chk("t3_a_good", 80'(a_good), 80'(4));
    send(7, 5, 1'b0, 1'b0, 1'b1);
    repeat (3) step();
    drain("t4_drain");
    chk("t4_a_err", 80'({a_good, a_err}), 80'({4'd4, 4'd1}));
    chk("t4_b_good_err", {16'd0, b_good, b_err}, {16'd0, 32'd7, 32'd0});
    tready = 1'b0;
    send(8, 16, 1'b1, 1'b1, 1'b1);
    send(9, 1, 1'b1, 1'b0, 1'b1);
    repeat (3) step();
    chk("t5_full_on_tlast", 80'({a_good, a_ovf, a_err}), 80'({4'd5, 4'd3, 4'd1}));
    tready = 1'b1;
    drain("t5_drain");
    send(10, 3, 1'b1, 1'b1, 1'b1);
    drain("t5_after_drain");
    chk("t5_a_good", 80'(a_good), 80'(6));
    chk("t5_b_good", 80'(b_good), 80'(10));
    rnd = 1'b1;
    for (int f = 0; f < 1000; f++) begin
      len = int'($urandom_range(1, 16));
      u = ($urandom_range(0, 7) != 0);
      send(100 + f, len, u, u, 1'b1);
      if (u) ng++;
      else nb++;
      repeat ($urandom_range(0, 3)) step();
      drain("rnd_drain");
    end
    rnd = 1'b0;
    tready = 1'b1;
    step();
    chk("rnd_a_cnt", 80'({a_good, a_ovf, a_err}), 80'({4'd15, 4'd3, (nb + 1 > 15) ? 4'd15 : 4'(nb + 1)}));
    chk("rnd_b_good", 80'(b_good), 80'(10 + ng + nb));
    chk("rnd_b_drops", 80'({b_ovf, b_err}), 80'(0));
    for (int i = 0; i < 5; i++) begin
      w = mk(900, i, 10, 1'b1);
      {s_tdata, s_tkeep, s_tlast} = w[73:1];
      s_tuser = 1'b1;
      s_tvalid = 1'b1;
      step();
    end
    aresetn = 1'b0;
    exp_a.delete();
    exp_b.delete();
    step();
    chk("midrst_idle", 80'({a_tvalid, b_tvalid}), 80'(0));
    chk("midrst_cnt", 80'({a_good, a_ovf, a_err} | b_good | b_ovf | b_err), 80'(0));
    step();
    aresetn = 1'b1;
    for (int i = 5; i < 10; i++) begin
      w = mk(900, i, 10, 1'b1);
      {s_tdata, s_tkeep, s_tlast} = w[73:1];
      s_tvalid = 1'b1;
      step();
    end
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    repeat (3) step();
    chk("tail_uncounted", 80'({a_good, a_ovf, a_err} | b_good | b_ovf | b_err), 80'(0));
    send(901, 4, 1'b1, 1'b1, 1'b1);
    drain("postrst_drain");
    chk("postrst_cnt", 80'({a_good, a_ovf, a_err}), 80'({4'd1, 4'd0, 4'd0}));
    chk("postrst_b_good", 80'(b_good), 80'(1));
    for (int k = 0; k < 20; k++) begin
      send(1000 + k, 1, 1'b1, 1'b1, 1'b1);
      repeat (3) step();
    end
    drain("sat_drain");
    chk("sat_a_good", 80'(a_good), 80'(15));
    chk("sat_b_good", 80'(b_good), 80'(21));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
